cordic_cos_pipeline: RTL and testbench

- Fully pipelined CORDIC cosine unit: IEEE-754 single-precision angle (radians) in, single-precision cos(angle) out.
- Internally converts to 22-bit signed fixed point and runs NUM_STAGES rotation-mode CORDIC iterations, one registered stage per iteration, then converts back to float.
- Serves as the cosine datapath of the floating-point accelerator and accepts a new operand every clock.

---
 rtl/cordic_pkg.sv | 27 ++
 rtl/cordic_iter.sv | 55 +++++
 rtl/cordic_cos_pipeline.sv | 127 ++++++++++++
 tb/tb_cordic_cos_pipeline.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared fixed-point types and constants for the CORDIC cosine pipeline.
// Angles and coordinates are signed Q2.20.
package cordic_pkg;

    localparam int unsigned FIX_W  = 22;
    localparam int unsigned FRAC_W = 20;
    localparam int unsigned ATAN_N = 20;

    typedef logic signed [FIX_W-1:0] fix_t;

    localparam fix_t K_INIT  = 22'sd636751;
    localparam fix_t ONE_FIX = 22'sd1048576;

    // round(atan(2^-i) * 2^20)
    localparam fix_t ATAN_TABLE [ATAN_N] = '{
        22'sd823550, 22'sd486170, 22'sd256879, 22'sd130396,
        22'sd65451,  22'sd32757,  22'sd16383,  22'sd8192,
        22'sd4096,   22'sd2048,   22'sd1024,   22'sd512,
        22'sd256,    22'sd128,    22'sd64,     22'sd32,
        22'sd16,     22'sd8,      22'sd4,      22'sd2
    };

    function automatic fix_t atan_at(input int unsigned idx);
        return (idx < ATAN_N) ? ATAN_TABLE[5'(idx)] : '0;
    endfunction

endpackage

// File: rtl/cordic_iter.sv
// One registered rotation-mode CORDIC iteration; SHIFT selects the
// micro-rotation angle atan(2^-SHIFT).
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int unsigned SHIFT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  fix_t i_x,
    input  fix_t i_y,
    input  fix_t i_z,
    input  logic i_valid,
    output fix_t o_x,
    output fix_t o_y,
    output fix_t o_z,
    output logic o_valid
);

    localparam fix_t ATAN_I = atan_at(SHIFT);

    fix_t w_x_sh;
    fix_t w_y_sh;
    logic w_pos;

    fix_t r_x;
    fix_t r_y;
    fix_t r_z;
    logic r_valid;

    assign w_x_sh = i_x >>> SHIFT;
    assign w_y_sh = i_y >>> SHIFT;
    assign w_pos  = ~i_z[FIX_W-1];

    // Rotate toward z = 0; d = +1 when the residual angle is non-negative
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_x     <= w_pos ? (i_x - w_y_sh) : (i_x + w_y_sh);
            r_y     <= w_pos ? (i_y + w_x_sh) : (i_y - w_x_sh);
            r_z     <= w_pos ? (i_z - ATAN_I) : (i_z + ATAN_I);
            r_valid <= i_valid;
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_z     = r_z;
    assign o_valid = r_valid;

endmodule

// File: rtl/cordic_cos_pipeline.sv
// Fully pipelined single-precision cosine: float->Q2.20, NUM_STAGES CORDIC
// iterations, Q2.20->float. Latency NUM_STAGES+2, one operand per clock.
module cordic_cos_pipeline
    import cordic_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] float_in,
    output logic        out_valid,
    output logic [31:0] float_out
);

    localparam logic [7:0] EXP_ONE    = 8'd127;
    localparam logic [7:0] EXP_MIN    = 8'd107;
    localparam logic [7:0] EXP_SHBASE = 8'd130;
    localparam logic [7:0] EXP_OUTLSB = 8'd107;

    logic        w_in_sign;
    logic [7:0]  w_in_exp;
    logic [22:0] w_in_man;
    logic        w_in_nan;
    fix_t        w_in_mag;
    fix_t        w_in_angle;

    fix_t        r_angle;
    logic        r_valid0;

    fix_t        w_x [NUM_STAGES+1];
    fix_t        w_y [NUM_STAGES+1];
    fix_t        w_z [NUM_STAGES+1];
    logic        w_v [NUM_STAGES+1];

    fix_t        w_xf;
    logic        w_xf_nonpos;
    logic [4:0]  w_msb;
    logic [FRAC_W:0] w_norm;
    logic [31:0] w_float;
    logic [2*FIX_W-1:0] w_unused_yz;

    logic [31:0] r_float_out;
    logic        r_out_valid;

    assign w_in_sign = float_in[31];
    assign w_in_exp  = float_in[30:23];
    assign w_in_man  = float_in[22:0];
    assign w_in_nan  = (w_in_exp == 8'hFF) && (w_in_man != '0);

    // |x| >= 1.0, Inf and NaN saturate; tiny exponents and denormals flush to 0
    always_comb begin
        w_in_mag = '0;
        if (w_in_exp >= EXP_ONE) begin
            w_in_mag = ONE_FIX;
        end else if (w_in_exp >= EXP_MIN) begin
            w_in_mag = FIX_W'({1'b1, w_in_man} >> (EXP_SHBASE - w_in_exp));
        end
        w_in_angle = (w_in_sign && !w_in_nan) ? -w_in_mag : w_in_mag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_angle  <= '0;
            r_valid0 <= 1'b0;
        end else begin
            r_angle  <= w_in_angle;
            r_valid0 <= in_valid;
        end
    end

    assign w_x[0] = K_INIT;
    assign w_y[0] = '0;
    assign w_z[0] = r_angle;
    assign w_v[0] = r_valid0;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_iter
        cordic_iter #(
            .SHIFT (g)
        ) u_iter (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_x     (w_x[g]),
            .i_y     (w_y[g]),
            .i_z     (w_z[g]),
            .i_valid (w_v[g]),
            .o_x     (w_x[g+1]),
            .o_y     (w_y[g+1]),
            .o_z     (w_z[g+1]),
            .o_valid (w_v[g+1])
        );
    end

    // Final sine and residual angle are not needed downstream
    assign w_unused_yz = {w_y[NUM_STAGES], w_z[NUM_STAGES]};

    assign w_xf        = w_x[NUM_STAGES];
    assign w_xf_nonpos = w_xf[FIX_W-1] || (w_xf == '0);

    always_comb begin
        w_msb = '0;
        for (int i = 0; i <= int'(FRAC_W); i++) begin
            if (w_xf[i]) begin
                w_msb = 5'(i);
            end
        end
    end

    // Leading one lands on bit FRAC_W; bits below it form the truncated mantissa
    assign w_norm  = w_xf[FRAC_W:0] << (5'(FRAC_W) - w_msb);
    assign w_float = w_xf_nonpos ? 32'h0
                   : {1'b0, 8'(EXP_OUTLSB + {3'b000, w_msb}), w_norm[FRAC_W-1:0], 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_float_out <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_float_out <= w_float;
            r_out_valid <= w_v[NUM_STAGES];
        end
    end

    assign float_out = r_float_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_cordic_cos_pipeline.sv
// Self-checking bench for cordic_cos_pipeline: directed and random operands
// compared against a real-arithmetic cosine reference.
module tb_cordic_cos_pipeline;

    localparam int  NUM_STAGES = 16;
    localparam int  LAT        = NUM_STAGES + 2;
    // Residual angle is modelled exactly; this bounds x/y shift truncation
    localparam real TOL        = 3.0e-5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] float_in = 32'h0;
    logic        out_valid;
    logic [31:0] float_out;

    int total = 0;
    int bad   = 0;

    logic        hist_v [$];
    logic [31:0] hist_d [$];

    always #5 clk = ~clk;

    cordic_cos_pipeline #(
        .NUM_STAGES (NUM_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .float_in  (float_in),
        .out_valid (out_valid),
        .float_out (float_out)
    );

    function automatic int atan_fix(input int i);
        return $rtoi($atan(2.0 ** (-i)) * 1048576.0 + 0.5);
    endfunction

    function automatic real to_real(input logic [31:0] f);
        int  e;
        real m;
        e = int'(f[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return f[31] ? -m : m;
    endfunction

    // Quantise the angle, find where the CORDIC angle decomposition ends up,
    // and return the exact cosine of that effective angle.
    function automatic real model_cos(input logic [31:0] f);
        int  e;
        int  q;
        int  z;
        bit  nan;
        real mag;
        e   = int'(f[30:23]);
        nan = (e == 255) && (f[22:0] != 0);
        if (nan || e >= 127) begin
            q = 1 << 20;
        end else if (e == 0) begin
            q = 0;
        end else begin
            mag = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
            q   = $rtoi(mag * 1048576.0);
        end
        if (f[31] && !nan) q = -q;
        z = q;
        for (int i = 0; i < NUM_STAGES; i++) begin
            z = (z >= 0) ? (z - atan_fix(i)) : (z + atan_fix(i));
        end
        return $cos(real'(q - z) / 1048576.0);
    endfunction

    task automatic chk_bits(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cos(input string tag, input logic [31:0] obs, input real exp);
        real o;
        real err;
        o   = to_real(obs);
        err = (o > exp) ? (o - exp) : (exp - o);
        total++;
        assert ((obs[31] === 1'b0) && (err <= TOL)) else begin
            bad++;
            $error("FAIL %s: observed=%h (%.7f) expected=%.7f", tag, obs, o, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [31:0] d);
        int n;
        in_valid = v;
        float_in = d;
        @(posedge clk);
        hist_v.push_back(v);
        hist_d.push_back(d);
        #1;
        n = hist_v.size();
        if (n >= LAT) begin
            chk_bits("out_valid", {31'b0, out_valid}, {31'b0, hist_v[n-LAT]});
            if (hist_v[n-LAT])
                chk_cos($sformatf("cos(%h)", hist_d[n-LAT]), float_out, model_cos(hist_d[n-LAT]));
        end else begin
            chk_bits("out_valid_fill", {31'b0, out_valid}, 32'h0);
        end
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_bits("reset_float_out", float_out, 32'h0);
        chk_bits("reset_out_valid", {31'b0, out_valid}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hist_v.delete();
        hist_d.delete();
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] d;
        logic        v;

        #12;
        chk_bits("por_float_out", float_out, 32'h0);
        chk_bits("por_out_valid", {31'b0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) tick(1'b1, 32'h3F800000);
        tick(1'b1, 32'h00000000);
        tick(1'b1, 32'hBF800000);
        tick(1'b1, 32'h3F000000);
        tick(1'b1, 32'hBE800000);
        tick(1'b1, 32'h3F400000);
        tick(1'b1, 32'h40000000);
        tick(1'b1, 32'h7F800000);
        tick(1'b1, 32'hFF800000);
        tick(1'b1, 32'h7FC00000);
        tick(1'b1, 32'h00000001);
        tick(1'b1, 32'h33800000);
        tick(1'b1, 32'hC0000000);
        tick(1'b1, 32'h3F7FFFFF);
        tick(1'b0, 32'h3F800000);
        tick(1'b1, 32'h3F000000);
        tick(1'b0, 32'h3F000000);
        tick(1'b1, 32'hBF000000);
        tick(1'b1, 32'h3E800000);
        tick(1'b0, 32'h3E800000);
        for (int i = 0; i < LAT; i++) tick(1'b0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            d = {r[31], 8'(100 + $urandom_range(0, 27)), r[22:0]};
            v = ($urandom_range(0, 3) != 0);
            tick(v, d);
        end

        for (int i = 0; i < LAT + 2; i++) tick(1'b1, 32'h3F000000);
        apply_reset();

        tick(1'b1, 32'h3F400000);
        tick(1'b1, 32'hBF400000);
        for (int i = 0; i < LAT + 2; i++) tick(1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
